// File: rtl/disp_pkg.sv
// disp_pkg: shared display timing constants and idle-output encodings
package disp_pkg;
  localparam int T1MS = 100000;
  localparam int NDIG = 4;
  localparam logic [NDIG-1:0] POS_NONE = 4'b1111;
  localparam logic DP_OFF = 1'b1;
endpackage

// File: rtl/disp_tick_gen.sv
// disp_tick_gen: free-running slot counter emitting a one-cycle tick every T_DIGIT clocks
module disp_tick_gen
  import disp_pkg::*;
#(
  parameter int T_DIGIT = T1MS
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  localparam int W = (T_DIGIT > 2) ? $clog2(T_DIGIT) : 1;
  localparam logic [W-1:0] LAST = W'(T_DIGIT - 1);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb begin
    tick  = cnt_q == LAST;
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/disp_scan_mux.sv
// disp_scan_mux: 4-digit BCD scan multiplexer with frame-committed double buffering (DISP_LZB_EN adds leading-zero blanking)
module disp_scan_mux
  import disp_pkg::*;
#(
  parameter int T_DIGIT = T1MS
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            LD,
  input  logic [15:0]     VAL,
  input  logic [3:0]      DPM,
  output logic [NDIG-1:0] POSB,
  output logic [3:0]      NUM,
  output logic            DP,
  output logic            PEND,
  output logic            FRAME
);
  logic            tick, bnd, blank;
  logic [1:0]      idx_q, idx_d;
  logic [15:0]     act_v_q, act_v_d, pnd_v_q, pnd_v_d;
  logic [3:0]      act_dp_q, act_dp_d, pnd_dp_q, pnd_dp_d;
  logic            pend_q, pend_d;
  logic [NDIG-1:0] posb_q, posb_d;
  logic [3:0]      num_q, num_d;
  logic            dp_q, dp_d, frame_q, frame_d;
  disp_tick_gen #(.T_DIGIT(T_DIGIT)) u_tick (
    .clk (CLK),
    .rst (RST),
    .tick(tick)
  );
  always_comb begin
    bnd      = tick && idx_q == 2'd3;
    idx_d    = tick ? idx_q + 2'd1 : idx_q;
    act_v_d  = bnd ? (LD ? VAL : pend_q ? pnd_v_q : act_v_q) : act_v_q;
    act_dp_d = bnd ? (LD ? DPM : pend_q ? pnd_dp_q : act_dp_q) : act_dp_q;
    pnd_v_d  = (LD && !bnd) ? VAL : pnd_v_q;
    pnd_dp_d = (LD && !bnd) ? DPM : pnd_dp_q;
    pend_d   = bnd ? 1'b0 : (LD | pend_q);
`ifdef DISP_LZB_EN
    blank    = idx_q != 2'd0 && (act_v_q >> {idx_q, 2'b00}) == 16'h0 && (act_dp_q >> idx_q) == 4'h0;
`else
    blank    = 1'b0;
`endif
    posb_d   = blank ? POS_NONE : ~(4'b0001 << idx_q);
    num_d    = blank ? 4'h0 : act_v_q[{idx_q, 2'b00} +: 4];
    dp_d     = blank ? DP_OFF : ~act_dp_q[idx_q];
    frame_d  = bnd;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      idx_q    <= 2'd0;
      act_v_q  <= 16'h0;
      act_dp_q <= 4'h0;
      pnd_v_q  <= 16'h0;
      pnd_dp_q <= 4'h0;
      pend_q   <= 1'b0;
      posb_q   <= POS_NONE;
      num_q    <= 4'h0;
      dp_q     <= DP_OFF;
      frame_q  <= 1'b0;
    end else begin
      idx_q    <= idx_d;
      act_v_q  <= act_v_d;
      act_dp_q <= act_dp_d;
      pnd_v_q  <= pnd_v_d;
      pnd_dp_q <= pnd_dp_d;
      pend_q   <= pend_d;
      posb_q   <= posb_d;
      num_q    <= num_d;
      dp_q     <= dp_d;
      frame_q  <= frame_d;
    end
  end
  assign POSB  = posb_q;
  assign NUM   = num_q;
  assign DP    = dp_q;
  assign PEND  = pend_q;
  assign FRAME = frame_q;
endmodule

// File: tb/tb_disp_scan_mux.sv
// tb_disp_scan_mux: randomized and directed checks of disp_scan_mux against a frame-arithmetic reference model
module tb_disp_scan_mux;
  localparam int T = 4;
  localparam int FR = 4 * T;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        LD = 1'b0;
  logic [15:0] VAL = 16'h0;
  logic [3:0]  DPM = 4'h0;
  logic [3:0]  POSB, NUM;
  logic        DP, PEND, FRAME;
  int checks = 0;
  int errors = 0;
  bit started = 0;
  int          n;
  logic [15:0] m_act_v, m_pv;
  logic [3:0]  m_act_d, m_pd;
  bit          m_pend;
  logic [3:0]  e_posb, e_num;
  logic        e_dp, e_pend, e_frame;

  disp_scan_mux #(.T_DIGIT(T)) dut (
    .CLK(CLK), .RST(RST), .LD(LD), .VAL(VAL), .DPM(DPM),
    .POSB(POSB), .NUM(NUM), .DP(DP), .PEND(PEND), .FRAME(FRAME)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(posedge CLK) begin
    int slot;
    bit bl;
    started = 1;
    if (RST) begin
      n = 0; m_act_v = 0; m_act_d = 0; m_pv = 0; m_pd = 0; m_pend = 0;
      e_posb = 4'hf; e_num = 0; e_dp = 1; e_pend = 0; e_frame = 0;
    end else begin
      slot = (n / T) % 4;
      bl = 0;
`ifdef DISP_LZB_EN
      bl = slot != 0 && (m_act_v >> (4 * slot)) == 0 && (m_act_d >> slot) == 0;
`endif
      e_posb  = bl ? 4'hf : ~(4'(1 << slot));
      e_num   = bl ? 4'h0 : 4'((m_act_v >> (4 * slot)) & 16'hf);
      e_dp    = bl ? 1'b1 : ~m_act_d[slot];
      e_frame = (n % FR) == FR - 1;
      if (e_frame) begin
        if (LD) begin m_act_v = VAL; m_act_d = DPM; end
        else if (m_pend) begin m_act_v = m_pv; m_act_d = m_pd; end
        m_pend = 0;
      end else if (LD) begin
        m_pv = VAL; m_pd = DPM; m_pend = 1;
      end
      e_pend = m_pend;
      n++;
    end
  end

  always @(negedge CLK) begin
    if (started) begin
      chk("posb", int'(POSB), int'(e_posb));
      chk("num", int'(NUM), int'(e_num));
      chk("dp", int'(DP), int'(e_dp));
      chk("pend", int'(PEND), int'(e_pend));
      chk("frame", int'(FRAME), int'(e_frame));
    end
  end

  task automatic cyc(input int k);
    repeat (k) @(negedge CLK);
  endtask

  task automatic wait_frame();
    bit seen = 0;
    for (int i = 0; i < 3 * FR && !seen; i++) begin
      @(negedge CLK);
      seen = FRAME;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL frame_timeout at %0t: got no FRAME expected FRAME within %0d cycles", $time, 3 * FR);
    end
  endtask

  task automatic load(input logic [15:0] v, input logic [3:0] d);
    LD = 1; VAL = v; DPM = d;
    @(negedge CLK);
    LD = 0;
  endtask

  initial begin
    cyc(3);
    chk("rst_posb", int'(POSB), 'hf);
    chk("rst_dp", int'(DP), 1);
    RST = 0;
    cyc(1);
    chk("first_posb", int'(POSB), 'he);
    chk("first_num", int'(NUM), 0);
    cyc(5);
    load(16'h1234, 4'b0100);
    chk("t2_pend", int'(PEND), 1);
    chk("t2_num_unchanged", int'(NUM), 0);
    wait_frame();
    cyc(1);
    chk("t2_s0_num", int'(NUM), 4);
    chk("t2_s0_posb", int'(POSB), 'he);
    chk("t2_pend_clr", int'(PEND), 0);
    cyc(T);
    chk("t2_s1_num", int'(NUM), 3);
    cyc(T);
    chk("t2_s2_num", int'(NUM), 2);
    chk("t2_s2_dp", int'(DP), 0);
    chk("t2_s2_posb", int'(POSB), 'hb);
    cyc(T);
    chk("t2_s3_num", int'(NUM), 1);
    chk("t2_s3_dp", int'(DP), 1);
    wait_frame();
    load(16'h1111, 4'h0);
    cyc(3);
    load(16'h5678, 4'h0);
    wait_frame();
    cyc(1);
    chk("t3_s0_num", int'(NUM), 8);
    cyc(T);
    chk("t3_s1_num", int'(NUM), 7);
    wait_frame();
    cyc(FR - 1);
    load(16'h9999, 4'h0);
    chk("t4_frame", int'(FRAME), 1);
    chk("t4_pend", int'(PEND), 0);
    cyc(1);
    chk("t4_num", int'(NUM), 9);
    load(16'h4321, 4'h0);
    chk("t6_pend", int'(PEND), 1);
    cyc(2 * T);
    RST = 1;
    cyc(1);
    chk("t6_rst_posb", int'(POSB), 'hf);
    chk("t6_rst_pend", int'(PEND), 0);
    RST = 0;
    wait_frame();
    cyc(1);
    chk("t6_num", int'(NUM), 0);
`ifdef DISP_LZB_EN
    load(16'h0070, 4'h0);
    wait_frame();
    cyc(1);
    chk("t5_s0_posb", int'(POSB), 'he);
    cyc(T);
    chk("t5_s1_num", int'(NUM), 7);
    cyc(T);
    chk("t5_s2_posb", int'(POSB), 'hf);
    load(16'h0000, 4'b1000);
    wait_frame();
    cyc(3 * T + 1);
    chk("t5_s3_posb", int'(POSB), 'h7);
    chk("t5_s3_dp", int'(DP), 0);
`endif
    for (int i = 0; i < 3000; i++) begin
      @(negedge CLK);
      RST = $urandom_range(0, 399) == 0;
      LD  = $urandom_range(0, 5) == 0;
      VAL = 16'($urandom) & (16'hffff >> (4 * $urandom_range(0, 4)));
      DPM = 4'($urandom) & (($urandom_range(0, 2) == 0) ? 4'hf : 4'h0);
    end
    @(negedge CLK);
    RST = 0; LD = 0;
    cyc(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
